dcache_direct_wb: RTL
=====================

Name: dcache_direct_wb

Overview:
- 8-bit-addressed, direct-mapped, write-back data cache between the CPU data port and the block-wide data memory.
- Serves the CPU's byte READ/WRITE on ADDRESS[7:0] and stalls the CPU through BUSYWAIT on a miss.
- On a miss, writes back a dirty victim block and fetches the new block as 32-bit words on the memory side.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; index width = 3.
- BLOCK_BYTES, 4, bytes per line; offset width = 2, so tag width = 3.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high.
- READ  input  1  CPU byte read request.
- WRITE  input  1  CPU byte write request.
- ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
- WRITEDATA  input  8  CPU store byte.
- READDATA  output  8  byte returned to CPU.
- BUSYWAIT  output  1  CPU stall; the CPU holds PC and request while high.
- mem_read  output  1  block fetch request to data memory.
- mem_write  output  1  block write-back request to data memory.
- mem_address  output  6  block address {tag,index}.
- mem_writedata  output  32  victim block; byte0 = bits[7:0].
- mem_readdata  input  32  fetched block; same byte order.
- mem_busywait  input  1  memory busy; the transfer completes on the first posedge with it low while mem_read or mem_write is high.

Behaviour:
- Storage per line: 32-bit data, 3-bit tag, valid bit, dirty bit.
- Hit = valid[index] & (tag[index]==ADDRESS[7:5]); evaluated combinationally.
- Request = READ | WRITE. If both are high, WRITE takes priority and READDATA shows the pre-write byte.
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE, no request:
  - BUSYWAIT=0, mem_read=0, mem_write=0.
- IDLE, read hit:
  - READDATA = selected byte, combinational within the same cycle; BUSYWAIT=0.
  - Zero-cycle stall.
- IDLE, write hit:
  - BUSYWAIT=0; byte written at posedge; dirty[index] set to 1.
- IDLE, miss:
  - BUSYWAIT=1 combinationally in the same cycle.
  - At posedge, next state is WRITEBACK if valid & dirty, else FETCH.
- WRITEBACK:
  - mem_write=1, mem_address={stored tag, index}, mem_writedata = line data.
  - Hold until a posedge with mem_busywait=0, then go to FETCH.
- FETCH:
  - mem_read=1, mem_address={ADDRESS[7:5], index}.
  - On a posedge with mem_busywait=0: line data = mem_readdata, tag = ADDRESS[7:5], valid=1, dirty=0; go to IDLE.
- Return to IDLE: the request now hits and completes as a hit in that cycle, so a write miss sets dirty after the fill.
- BUSYWAIT=1 in WRITEBACK and FETCH regardless of hit.
- mem_read and mem_write are never high together; both are 0 in IDLE.
- Miss latency, clean: 1 (IDLE→FETCH) + memory wait cycles + 1 hit cycle.
- Miss latency, dirty: the same plus the write-back transfer.
- READDATA when no read is in progress: the byte at the current ADDRESS; don't-care to the CPU.
- Request dropped mid-miss (READ=WRITE=0 in WRITEBACK/FETCH): the in-flight transfer completes, then IDLE.
- RESET high at posedge:
  - state=IDLE; all valid=0 and dirty=0.
  - mem_read=0, mem_write=0 from the next cycle.
  - An in-flight memory transfer is abandoned; data/tag arrays are not cleared.
- Write hit and a miss cannot occur simultaneously: one request per cycle, address held while BUSYWAIT is high.

Test Plan:
- Reset, then READ ADDRESS=0x00 with memory holding word 0x44332211 at block 0 and 5-cycle latency → BUSYWAIT high about 7 cycles, mem_read pulses with mem_address=0, then READDATA=0x11 and BUSYWAIT low.
- Read 0x03 right after → hit, BUSYWAIT stays 0, READDATA=0x44 in the same cycle.
- WRITE 0xAB to 0x01 (hit) → no stall; a subsequent read of 0x01 returns 0xAB; mem_write never asserted.
- READ 0x20 (same index 0, tag 1) with line 0 dirty → mem_write with mem_address=0x00 and mem_writedata=0x4433AB11, then mem_read with mem_address=0x08, then READDATA from the new block.
- WRITE to 0x44 (clean miss) → FETCH only, no WRITEBACK; after the fill the byte is updated and dirty=1; a later conflicting access 0x64 triggers a write-back of address 0x11.
- Assert RESET during FETCH → mem_read low the next cycle, BUSYWAIT low in IDLE; re-reading 0x00 misses again (valid cleared).

Source files
------------

// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back data cache, 8 lines of 4 bytes.
// Stalls the CPU on a miss while a dirty victim is written back and the line refilled.
module dcache_direct_wb (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FETCH
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_data [8];
  logic [2:0]  r_tag [8];
  logic [7:0]  r_valid;
  logic [7:0]  r_dirty;

  logic [2:0]  w_tag;
  logic [2:0]  w_idx;
  logic [1:0]  w_off;
  logic [31:0] w_line;
  logic        w_req;
  logic        w_hit;
  logic        w_whit;
  logic        w_fill;

  assign w_tag  = ADDRESS[7:5];
  assign w_idx  = ADDRESS[4:2];
  assign w_off  = ADDRESS[1:0];
  assign w_line = r_data[w_idx];
  assign w_req  = READ | WRITE;
  assign w_hit  = r_valid[w_idx]
                & (r_tag[w_idx] == w_tag);

  assign READDATA = 8'(w_line >> {w_off, 3'b000});

  always_comb begin
    w_next        = r_state;
    BUSYWAIT      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {w_tag, w_idx};
    mem_writedata = w_line;
    w_whit        = 1'b0;
    w_fill        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_whit = WRITE;
          end else begin
            BUSYWAIT = 1'b1;
            w_next   = (r_valid[w_idx] & r_dirty[w_idx])
                     ? S_WB : S_FETCH;
          end
        end
      end
      S_WB: begin
        BUSYWAIT    = 1'b1;
        mem_write   = 1'b1;
        mem_address = {r_tag[w_idx], w_idx};
        if (!mem_busywait) w_next = S_FETCH;
      end
      S_FETCH: begin
        BUSYWAIT = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) begin
          w_fill = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_whit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays are left untouched by reset; valid gates them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (w_fill) begin
        r_data[w_idx] <= mem_readdata;
        r_tag[w_idx]  <= w_tag;
      end else if (w_whit) begin
        r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
      end
    end
  end

endmodule
